rps_player: RTL and testbench
=============================

Name: rps_player

Overview:
- Synthesizable player agent for the rock-paper-scissors referee.
- It sits on one player port of the referee, on the opposite side of the r/p/s/go/score pins, so two instances can play each other through the referee without a class-based bench.
- On each go request it picks a move by the selected strategy, drives a one-hot r/p/s pulse, then watches for a score pulse.
- It keeps win and round counters.

Parameters:
- THINK_CYCLES, 2: cycles between the go pulse and the move pulse (0..15).
- RESULT_WIN, 4: cycles after the move pulse during which a score pulse counts as a win (1..15).
- CNT_W, 8: width of the win and round counters.
- LFSR_SEED, 16'hACE1: reset value of the random-move LFSR (must be non-zero).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- go  in  1  one-cycle move request from the referee.
- score  in  1  one-cycle pulse: this player won the last round.
- dut_busy  in  1  referee evaluating; no move may be driven while high.
- mode  in  2  strategy: 0 fixed, 1 cycle, 2 random, 3 win-stay/lose-shift.
- fixed_move  in  2  move for mode 0: 0=R, 1=P, 2=S; 3 is treated as R.
- r  out  1  rock pulse.
- p  out  1  paper pulse.
- s  out  1  scissors pulse.
- wins  out  CNT_W  saturating count of rounds won.
- rounds  out  CNT_W  saturating count of moves played.
- busy  out  1  high in any state other than IDLE.
- proto_err  out  1  sticky: go seen while not IDLE.

Behaviour:
- Reset: synchronous, active-high; one cycle suffices and it is honoured in every state.
  - r, p, s, wins, rounds, busy, proto_err = 0; state = IDLE; LFSR = LFSR_SEED; last_move = R; last_won = 0.
  - Reset mid-round aborts the round with no move emitted and no counter update.
- State machine, registered outputs:
  - IDLE: go=1 -> THINK with think counter = THINK_CYCLES. The move is chosen on this same cycle and latched into next_move.
  - THINK: the counter decrements each cycle. At 0, if dut_busy=0 -> PLAY; otherwise hold in THINK until dut_busy=0. With THINK_CYCLES=0, THINK lasts exactly one cycle when not busy.
  - PLAY: exactly one of r/p/s is high for exactly this one cycle. rounds += 1, saturating at all-ones. last_move = next_move. Next state WAIT with window counter = RESULT_WIN.
  - WAIT: a score=1 sample sets won. The counter decrements; at 0 go to IDLE. On that exit: wins += won (saturating) and last_won = won.
  - A score pulse in any state other than WAIT is ignored.
- Latency: go at cycle N -> move pulse at N+1+THINK_CYCLES when dut_busy stays low.
- Move selection, evaluated in IDLE on go:
  - mode 0: fixed_move.
  - mode 1: successor of last_move (R->P->S->R).
  - mode 2: LFSR[1:0], with 0=R, 1=P, 2=S; value 3 maps to P if LFSR[2]=1, else S.
  - mode 3: last_move if last_won=1, else successor of last_move.
- mode changes take effect at the next go; an in-flight next_move is unaffected.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances once per go accepted in IDLE, in every mode, so the sequence is deterministic with respect to the go count.
- Protocol errors:
  - go while busy=1 sets proto_err and is otherwise ignored; no extra move is emitted and the current round continues.
  - proto_err clears only on rst.
- Invariants:
  - r+p+s <= 1 every cycle.
  - No r/p/s pulse in any cycle where dut_busy=1.
  - go and score pulses on the same cycle in IDLE: go is accepted, score is ignored.

Test Plan:
- Reset, then mode 0, fixed_move=2, go at cycle 10 -> s=1 at cycle 13 only; rounds=1; wins=0 after the window closes; busy high for cycles 11..17.
- Mode 1, last_move=R after reset, 4 go pulses spaced 10 cycles apart -> moves P, S, R, P; rounds=4.
- Mode 3, go, score pulse 2 cycles after the move, then go, then go with no score -> moves P, P, S; wins=1.
- go, with dut_busy held high for 5 cycles from the THINK expiry -> move appears on the first cycle after dut_busy falls; no r/p/s pulse while busy.
- go again 1 cycle after an accepted go -> proto_err=1; exactly one move pulse; rounds=1; rst clears proto_err.
- CNT_W=2, mode 0, 5 rounds each followed by a score pulse -> wins=3 and rounds=3 (saturated); mode 2 from seed 16'hACE1 matches the bench LFSR model over 100 rounds.

Source files
------------

// File: rtl/rps_player.sv
// Rock-paper-scissors player agent for one referee port: picks a move per go
// request by the selected strategy, pulses r/p/s, then scores the round.
module rps_player #(
    parameter int unsigned THINK_CYCLES = 2,
    parameter int unsigned RESULT_WIN   = 4,
    parameter int unsigned CNT_W        = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             score,
    input  logic             dut_busy,
    input  logic [1:0]       mode,
    input  logic [1:0]       fixed_move,
    output logic             r,
    output logic             p,
    output logic             s,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] rounds,
    output logic             busy,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        THINK = 2'd1,
        PLAY  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [1:0]       MOVE_R     = 2'd0;
    localparam logic [1:0]       MOVE_P     = 2'd1;
    localparam logic [1:0]       MOVE_S     = 2'd2;
    localparam logic [3:0]       THINK_LOAD = 4'(THINK_CYCLES);
    localparam logic [3:0]       WIN_LOAD   = 4'(RESULT_WIN);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [1:0] succ_move(input logic [1:0] m);
        case (m)
            MOVE_R:  succ_move = MOVE_P;
            MOVE_P:  succ_move = MOVE_S;
            default: succ_move = MOVE_R;
        endcase
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        lfsr_next = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [1:0] lfsr_move(input logic [15:0] l);
        case (l[1:0])
            2'd0:    lfsr_move = MOVE_R;
            2'd1:    lfsr_move = MOVE_P;
            2'd2:    lfsr_move = MOVE_S;
            default: lfsr_move = l[2] ? MOVE_P : MOVE_S;
        endcase
    endfunction

    function automatic logic [2:0] move_onehot(input logic [1:0] m);
        case (m)
            MOVE_R:  move_onehot = 3'b100;
            MOVE_P:  move_onehot = 3'b010;
            MOVE_S:  move_onehot = 3'b001;
            default: move_onehot = 3'b100;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    function automatic logic [1:0] pick_move(input logic [1:0]  md,
                                             input logic [1:0]  fx,
                                             input logic [1:0]  last,
                                             input logic        last_won,
                                             input logic [15:0] l);
        case (md)
            2'd0:    pick_move = (fx == 2'd3) ? MOVE_R : fx;
            2'd1:    pick_move = succ_move(last);
            2'd2:    pick_move = lfsr_move(l);
            default: pick_move = last_won ? last : succ_move(last);
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [3:0]       cnt_r, cnt_s;
    logic [1:0]       next_move_r, next_move_s;
    logic [1:0]       last_move_r, last_move_s;
    logic             last_won_r, last_won_s;
    logic             won_r, won_s;
    logic             won_now_s;
    logic [15:0]      lfsr_r, lfsr_s;
    logic [2:0]       pulse_r, pulse_s;
    logic [CNT_W-1:0] wins_r, wins_s;
    logic [CNT_W-1:0] rounds_r, rounds_s;
    logic             busy_r;
    logic             proto_err_r, proto_err_s;

    // Next-state and datapath decode; the move pulse is registered on entry to PLAY.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        next_move_s = next_move_r;
        last_move_s = last_move_r;
        last_won_s  = last_won_r;
        won_s       = won_r;
        lfsr_s      = lfsr_r;
        pulse_s     = 3'b000;
        wins_s      = wins_r;
        rounds_s    = rounds_r;
        proto_err_s = proto_err_r;
        won_now_s   = won_r | score;

        if (go && (state_r != IDLE)) begin
            proto_err_s = 1'b1;
        end else begin
            proto_err_s = proto_err_r;
        end

        case (state_r)
            IDLE: begin
                if (go) begin
                    state_s     = THINK;
                    cnt_s       = THINK_LOAD;
                    next_move_s = pick_move(mode, fixed_move, last_move_r, last_won_r, lfsr_r);
                    lfsr_s      = lfsr_next(lfsr_r);
                end else begin
                    state_s = IDLE;
                end
            end
            THINK: begin
                // A count of 0 or 1 both mean this is the last thinking cycle.
                if (cnt_r > 4'd1) begin
                    cnt_s = cnt_r - 4'd1;
                end else if (!dut_busy) begin
                    cnt_s   = 4'd0;
                    state_s = PLAY;
                    pulse_s = move_onehot(next_move_r);
                end else begin
                    cnt_s   = 4'd0;
                    state_s = THINK;
                end
            end
            PLAY: begin
                rounds_s    = sat_inc(rounds_r);
                last_move_s = next_move_r;
                state_s     = WAIT;
                cnt_s       = WIN_LOAD;
                won_s       = 1'b0;
            end
            WAIT: begin
                if (cnt_r > 4'd1) begin
                    cnt_s = cnt_r - 4'd1;
                    won_s = won_now_s;
                end else begin
                    state_s    = IDLE;
                    cnt_s      = 4'd0;
                    won_s      = 1'b0;
                    last_won_s = won_now_s;
                    wins_s     = won_now_s ? sat_inc(wins_r) : wins_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            next_move_r <= MOVE_R;
            last_move_r <= MOVE_R;
            last_won_r  <= 1'b0;
            won_r       <= 1'b0;
            lfsr_r      <= LFSR_SEED;
            pulse_r     <= 3'b000;
            wins_r      <= {CNT_W{1'b0}};
            rounds_r    <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            next_move_r <= next_move_s;
            last_move_r <= last_move_s;
            last_won_r  <= last_won_s;
            won_r       <= won_s;
            lfsr_r      <= lfsr_s;
            pulse_r     <= pulse_s;
            wins_r      <= wins_s;
            rounds_r    <= rounds_s;
            busy_r      <= (state_s != IDLE);
            proto_err_r <= proto_err_s;
        end
    end

    assign r         = pulse_r[2];
    assign p         = pulse_r[1];
    assign s         = pulse_r[0];
    assign wins      = wins_r;
    assign rounds    = rounds_r;
    assign busy      = busy_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_rps_player.sv
// Self-checking bench for rps_player: directed scenarios plus randomized rounds
// checked against a rule-level model of move choice, LFSR and counters.
module tb_rps_player;

    localparam int T = 2;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0;
    logic       score = 1'b0;
    logic       dut_busy = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] fixed_move = 2'd0;
    logic       r, p, s, busy, proto_err;
    logic [7:0] wins, rounds;
    logic       r2, p2, s2, busy2, proto_err2;
    logic [1:0] wins2, rounds2;

    int total = 0;
    int bad = 0;

    rps_player #(.THINK_CYCLES(T), .RESULT_WIN(W), .CNT_W(8), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .go(go), .score(score), .dut_busy(dut_busy),
        .mode(mode), .fixed_move(fixed_move), .r(r), .p(p), .s(s),
        .wins(wins), .rounds(rounds), .busy(busy), .proto_err(proto_err));

    rps_player #(.THINK_CYCLES(T), .RESULT_WIN(W), .CNT_W(2), .LFSR_SEED(16'hACE1)) dut2 (
        .clk(clk), .rst(rst), .go(go), .score(score), .dut_busy(dut_busy),
        .mode(mode), .fixed_move(fixed_move), .r(r2), .p(p2), .s(s2),
        .wins(wins2), .rounds(rounds2), .busy(busy2), .proto_err(proto_err2));

    always #5 clk = ~clk;

    // Reference model: moves 0=R 1=P 2=S, counters saturate at their width.
    int m_last, m_won, m_lfsr, m_wins, m_rounds, m_wins2, m_rounds2;

    task automatic model_reset();
        m_last = 0; m_won = 0; m_lfsr = 'hACE1;
        m_wins = 0; m_rounds = 0; m_wins2 = 0; m_rounds2 = 0;
    endtask

    task automatic model_go(input int md, input int fx, output int mv);
        int v, fb;
        case (md)
            0: mv = (fx == 3) ? 0 : fx;
            1: mv = (m_last + 1) % 3;
            2: begin
                v = m_lfsr % 4;
                if (v == 3) mv = (((m_lfsr / 4) % 2) == 1) ? 1 : 2;
                else mv = v;
            end
            default: mv = (m_won != 0) ? m_last : (m_last + 1) % 3;
        endcase
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) % 65536;
    endtask

    task automatic model_end(input int mv, input int won);
        m_last = mv; m_won = won;
        m_rounds = (m_rounds < 255) ? m_rounds + 1 : 255;
        m_rounds2 = (m_rounds2 < 3) ? m_rounds2 + 1 : 3;
        if (won != 0) begin
            m_wins = (m_wins < 255) ? m_wins + 1 : 255;
            m_wins2 = (m_wins2 < 3) ? m_wins2 + 1 : 3;
        end
    endtask

    function automatic logic [2:0] exp_vec(input int mv);
        logic [2:0] one;
        one = 3'b100;
        return one >> mv;
    endfunction

    // Cycle in which the pulse must appear given a dut_busy window [bf, bf+bl).
    function automatic int exp_pulse(input int bf, input int bl);
        int c;
        c = (T > 1) ? T : 1;
        while (c >= bf && c < bf + bl) c++;
        return c + 1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; go = 1'b0; score = 1'b0; dut_busy = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one round from a go in the current cycle; relative cycle 0 is the go cycle.
    task automatic run_round(input int score_off, input int bf, input int bl,
                             input int extra_go, input bit score_at_go, input bit scramble,
                             output int pulse_rel, output logic [2:0] vec, output logic [2:0] vec2,
                             output int npulse, output int viol, output int busy_cyc, output bit done);
        pulse_rel = -1; vec = 3'b000; vec2 = 3'b000;
        npulse = 0; viol = 0; busy_cyc = 0; done = 1'b0;
        go = 1'b1; score = score_at_go; dut_busy = 1'b0;
        for (int rel = 1; rel <= 80 && !done; rel++) begin
            tick();
            go = (rel == extra_go);
            dut_busy = (rel >= bf && rel < bf + bl);
            if (scramble && rel == 1) begin
                mode = 2'($urandom_range(0, 3));
                fixed_move = 2'($urandom_range(0, 3));
            end
            if ({r, p, s} != 3'b000) begin
                npulse++;
                if (pulse_rel < 0) begin
                    pulse_rel = rel; vec = {r, p, s}; vec2 = {r2, p2, s2};
                end
                if (dut_busy) viol++;
                if ($countones({r, p, s}) > 1) viol++;
            end
            score = (pulse_rel >= 0 && score_off >= 0 && rel == pulse_rel + score_off);
            if (busy) busy_cyc++;
            if (busy2 !== busy) viol++;
            if (!busy && rel > 1) done = 1'b1;
        end
        go = 1'b0; score = 1'b0; dut_busy = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({r, p, s, wins, rounds, busy, proto_err} !== 21'd0) begin
            bad++; $display("FAIL reset_state: got %h want 0", {r, p, s, wins, rounds, busy, proto_err});
        end
        go = 1'b1; tick(); go = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0; model_reset();
        total++;
        if ({busy, r, p, s, rounds} !== 12'd0) begin
            bad++; $display("FAIL reset_midround: got %h want 0", {busy, r, p, s, rounds});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({r, p, s, busy, rounds} !== 12'd0) begin
                bad++; $display("FAIL reset_abort_quiet: cycle %0d got %h want 0", i, {r, p, s, busy, rounds});
            end
        end
    endtask

    task automatic test_fixed();
        int pr, np, vi, bc, mv; logic [2:0] v, v2; bit dn;
        do_reset();
        mode = 2'd0; fixed_move = 2'd2;
        model_go(0, 2, mv);
        run_round(-1, 0, 0, 0, 1'b0, 1'b0, pr, v, v2, np, vi, bc, dn);
        model_end(mv, 0);
        total++;
        if (pr != T + 1 || v !== 3'b001 || np != 1 || !dn) begin
            bad++; $display("FAIL fixed_move: got rel=%0d vec=%b n=%0d want rel=%0d vec=001 n=1", pr, v, np, T + 1);
        end
        total++;
        if (bc != T + 1 + W) begin
            bad++; $display("FAIL fixed_busy_len: got %0d want %0d", bc, T + 1 + W);
        end
        total++;
        if (rounds !== 8'd1 || wins !== 8'd0 || vi != 0) begin
            bad++; $display("FAIL fixed_counters: got rounds=%0d wins=%0d viol=%0d want 1 0 0", rounds, wins, vi);
        end
    endtask

    task automatic test_cycle();
        int pr, np, vi, bc, mv; logic [2:0] v, v2; bit dn;
        int want[4];
        want = '{1, 2, 0, 1};
        do_reset();
        mode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            model_go(1, 0, mv);
            run_round(-1, 0, 0, 0, 1'b0, 1'b0, pr, v, v2, np, vi, bc, dn);
            model_end(mv, 0);
            total++;
            if (v !== exp_vec(want[i]) || np != 1) begin
                bad++; $display("FAIL cycle_move %0d: got %b want %b", i, v, exp_vec(want[i]));
            end
            for (int g = 0; g < 2; g++) tick();
        end
        total++;
        if (rounds !== 8'd4) begin
            bad++; $display("FAIL cycle_rounds: got %0d want 4", rounds);
        end
    endtask

    task automatic test_wsls();
        int pr, np, vi, bc, mv; logic [2:0] v, v2; bit dn;
        int want[3], off[3];
        want = '{1, 1, 2}; off = '{2, -1, -1};
        do_reset();
        mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            model_go(3, 0, mv);
            run_round(off[i], 0, 0, 0, 1'b0, 1'b0, pr, v, v2, np, vi, bc, dn);
            model_end(mv, (off[i] > 0) ? 1 : 0);
            total++;
            if (v !== exp_vec(want[i])) begin
                bad++; $display("FAIL wsls_move %0d: got %b want %b", i, v, exp_vec(want[i]));
            end
        end
        total++;
        if (wins !== 8'd1 || rounds !== 8'd3) begin
            bad++; $display("FAIL wsls_counters: got wins=%0d rounds=%0d want 1 3", wins, rounds);
        end
    endtask

    task automatic test_dut_busy();
        int pr, np, vi, bc, mv; logic [2:0] v, v2; bit dn;
        do_reset();
        mode = 2'd0; fixed_move = 2'd0;
        model_go(0, 0, mv);
        run_round(-1, T, 5, 0, 1'b0, 1'b0, pr, v, v2, np, vi, bc, dn);
        model_end(mv, 0);
        total++;
        if (pr != exp_pulse(T, 5) || v !== 3'b100 || np != 1 || vi != 0) begin
            bad++; $display("FAIL busy_hold: got rel=%0d vec=%b n=%0d viol=%0d want rel=%0d vec=100 n=1 viol=0",
                            pr, v, np, vi, exp_pulse(T, 5));
        end
    endtask

    task automatic test_proto();
        int pr, np, vi, bc, mv; logic [2:0] v, v2; bit dn;
        do_reset();
        mode = 2'd0; fixed_move = 2'd1;
        run_round(-1, 0, 0, 1, 1'b0, 1'b0, pr, v, v2, np, vi, bc, dn);
        total++;
        if (proto_err !== 1'b1 || proto_err2 !== 1'b1 || np != 1 || rounds !== 8'd1 || v !== 3'b010) begin
            bad++; $display("FAIL proto_err: got err=%b n=%0d rounds=%0d vec=%b want 1 1 1 010", proto_err, np, rounds, v);
        end
        tick();
        total++;
        if (proto_err !== 1'b1) begin
            bad++; $display("FAIL proto_sticky: got %b want 1", proto_err);
        end
        do_reset();
        total++;
        if (proto_err !== 1'b0) begin
            bad++; $display("FAIL proto_clear: got %b want 0", proto_err);
        end
    endtask

    task automatic test_back_to_back();
        int pr, np, vi, bc, mv; logic [2:0] v, v2; bit dn;
        do_reset();
        mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            model_go(3, 0, mv);
            run_round(-1, 0, 0, 0, (i != 0), 1'b0, pr, v, v2, np, vi, bc, dn);
            model_end(mv, 0);
            total++;
            if (v !== exp_vec(mv) || pr != T + 1) begin
                bad++; $display("FAIL b2b_move %0d: got %b at %0d want %b at %0d", i, v, pr, exp_vec(mv), T + 1);
            end
        end
        total++;
        if (wins !== 8'd0 || rounds !== 8'd3) begin
            bad++; $display("FAIL b2b_counters: got wins=%0d rounds=%0d want 0 3", wins, rounds);
        end
    endtask

    task automatic test_saturate();
        int pr, np, vi, bc, mv; logic [2:0] v, v2; bit dn;
        do_reset();
        mode = 2'd0; fixed_move = 2'd3;
        for (int i = 0; i < 5; i++) begin
            model_go(0, 3, mv);
            run_round(1, 0, 0, 0, 1'b0, 1'b0, pr, v, v2, np, vi, bc, dn);
            model_end(mv, 1);
            total++;
            if (v2 !== 3'b100) begin
                bad++; $display("FAIL sat_move %0d: got %b want 100", i, v2);
            end
        end
        total++;
        if (wins2 !== 2'd3 || rounds2 !== 2'd3 || wins !== 8'd5 || rounds !== 8'd5) begin
            bad++; $display("FAIL saturate: got w2=%0d r2=%0d w=%0d r=%0d want 3 3 5 5", wins2, rounds2, wins, rounds);
        end
    endtask

    // Randomized rounds; all_modes=0 keeps mode 2 to follow the LFSR sequence.
    task automatic test_random(input bit all_modes, input int n);
        int pr, np, vi, bc, mv, md, fx, so, bf, bl, won; logic [2:0] v, v2; bit dn;
        do_reset();
        for (int i = 0; i < n; i++) begin
            md = all_modes ? $urandom_range(0, 3) : 2;
            fx = $urandom_range(0, 3);
            so = $urandom_range(0, W + 1) - 1;
            bf = $urandom_range(1, T);
            bl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            mode = 2'(md); fixed_move = 2'(fx);
            model_go(md, fx, mv);
            run_round(so, bf, bl, 0, 1'b0, all_modes, pr, v, v2, np, vi, bc, dn);
            won = (so >= 1 && so <= W) ? 1 : 0;
            model_end(mv, won);
            total++;
            if (v !== exp_vec(mv) || v2 !== exp_vec(mv) || np != 1 || vi != 0 || pr != exp_pulse(bf, bl) || !dn) begin
                bad++; $display("FAIL random_round %0d mode %0d: got vec=%b rel=%0d n=%0d viol=%0d want vec=%b rel=%0d",
                                i, md, v, pr, np, vi, exp_vec(mv), exp_pulse(bf, bl));
            end
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
        end
        total++;
        if (wins !== 8'(m_wins) || rounds !== 8'(m_rounds) || wins2 !== 2'(m_wins2) || rounds2 !== 2'(m_rounds2)) begin
            bad++; $display("FAIL random_counters: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                            wins, rounds, wins2, rounds2, m_wins, m_rounds, m_wins2, m_rounds2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick();
        test_reset();
        test_fixed();
        test_cycle();
        test_wsls();
        test_dut_busy();
        test_proto();
        test_back_to_back();
        test_saturate();
        test_random(1'b0, 100);
        test_random(1'b1, 80);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
